// File: rtl/mem_arbiter_pkg.sv
// Shared configuration constants and memory-port types used by the arbiter and
// by the core/ram blocks it connects.
package configure;

  localparam int ARB_TIMEOUT = 64;

endpackage

package wires;

  typedef struct packed {
    logic        mem_valid;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic        mem_error;
  } mem_out_type;

  typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_type;
  typedef enum logic {ARB_IMEM, ARB_DMEM} arb_port_type;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares the single RAM port between instruction fetch
// (imem) and data (dmem), with per-port request holding and a RAM timeout.
module mem_arbiter
  import configure::*;
  import wires::*;
#(
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic        reset,
  input  logic        clock,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  ram_in,
  input  mem_out_type ram_out
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  arb_state_type state_q, state_d;
  arb_port_type  owner_q, owner_d;
  arb_port_type  last_grant_q, last_grant_d;
  logic [TW-1:0] timer_q, timer_d;

  logic pend_i_q, pend_i_d, pend_d_q, pend_d_d;
  logic busy_i_q, busy_i_d, busy_d_q, busy_d_d;

  mem_in_type  hold_i_q, hold_i_d, hold_d_q, hold_d_d;
  mem_in_type  ram_in_q, ram_in_d;
  mem_out_type imem_out_q, imem_out_d, dmem_out_q, dmem_out_d;

  logic        accept_i, accept_d;
  logic        cand_i, cand_d;
  logic        grant_dmem;
  mem_in_type  req_i, req_d;
  mem_out_type resp;

  assign imem_out = imem_out_q;
  assign dmem_out = dmem_out_q;
  assign ram_in   = ram_in_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      owner_q      <= ARB_IMEM;
      last_grant_q <= ARB_DMEM;
      timer_q      <= '0;
      pend_i_q     <= 1'b0;
      pend_d_q     <= 1'b0;
      busy_i_q     <= 1'b0;
      busy_d_q     <= 1'b0;
      hold_i_q     <= '0;
      hold_d_q     <= '0;
      ram_in_q     <= '0;
      imem_out_q   <= '0;
      dmem_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      pend_i_q     <= pend_i_d;
      pend_d_q     <= pend_d_d;
      busy_i_q     <= busy_i_d;
      busy_d_q     <= busy_d_d;
      hold_i_q     <= hold_i_d;
      hold_d_q     <= hold_d_d;
      ram_in_q     <= ram_in_d;
      imem_out_q   <= imem_out_d;
      dmem_out_q   <= dmem_out_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    pend_i_d     = pend_i_q;
    pend_d_d     = pend_d_q;
    busy_i_d     = busy_i_q;
    busy_d_d     = busy_d_q;
    hold_i_d     = hold_i_q;
    hold_d_d     = hold_d_q;
    ram_in_d     = ram_in_q;
    ram_in_d.mem_valid = 1'b0;
    imem_out_d   = '0;
    dmem_out_d   = '0;
    resp         = '0;

    // A busy port already owns an outstanding transaction; extra pulses are dropped.
    accept_i = imem_in.mem_valid & ~busy_i_q;
    accept_d = dmem_in.mem_valid & ~busy_d_q;
    if (accept_i) begin
      hold_i_d = imem_in;
      pend_i_d = 1'b1;
      busy_i_d = 1'b1;
    end
    if (accept_d) begin
      hold_d_d = dmem_in;
      pend_d_d = 1'b1;
      busy_d_d = 1'b1;
    end

    // Same-cycle bypass lets an idle arbiter issue a fresh request one cycle later.
    cand_i     = pend_i_q | accept_i;
    cand_d     = pend_d_q | accept_d;
    req_i      = accept_i ? imem_in : hold_i_q;
    req_d      = accept_d ? dmem_in : hold_d_q;
    grant_dmem = cand_d & (~cand_i | (last_grant_q == ARB_IMEM));

    case (state_q)
      ARB_IDLE: begin
        if (cand_i | cand_d) begin
          if (grant_dmem) begin
            ram_in_d = req_d;
            pend_d_d = 1'b0;
            owner_d  = ARB_DMEM;
          end else begin
            ram_in_d = req_i;
            pend_i_d = 1'b0;
            owner_d  = ARB_IMEM;
          end
          ram_in_d.mem_valid = 1'b1;
          timer_d            = '0;
          state_d            = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (ram_out.mem_ready || (timer_q == TIMER_LAST)) begin
          if (ram_out.mem_ready) begin
            resp = ram_out;
          end else begin
            resp.mem_ready = 1'b1;
            resp.mem_error = 1'b1;
          end
          if (owner_q == ARB_IMEM) begin
            imem_out_d = resp;
            busy_i_d   = 1'b0;
          end else begin
            dmem_out_d = resp;
            busy_d_d   = 1'b0;
          end
          last_grant_d = owner_q;
          state_d      = ARB_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule
